block_dispatcher: RTL and testbench

Block scheduler between the device control register and the compute cores. On `start` it takes the kernel thread count (the DCR `thread_count` output) and splits it into blocks of `THREADS_PER_BLOCK` threads. It hands blocks one at a time to idle cores through per-core start/reset handshakes. It asserts `done` once every dispatched block has reported completion.

---
 rtl/block_dispatcher.sv | 159 +++++++++++++++
 tb/tb_block_dispatcher.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : block_dispatcher
// Purpose  : Splits a kernel's thread count into fixed-size blocks and hands
//            them one per cycle to idle compute cores, raising done once every
//            dispatched block has reported completion.
// Ports    : clk               - clock, rising edge
//            reset             - synchronous, active-low
//            start             - launches a kernel when seen in IDLE
//            thread_count      - total kernel threads (latched at launch)
//            core_done         - per-core block completion pulses
//            core_start        - per-core "owns a block" level
//            core_reset        - per-core "idle / released" level
//            core_block_id     - per-core block index, 8 bits per core
//            core_thread_count - per-core valid threads in the block, TW bits
//            done              - kernel complete, held until reset
// Revision : 1.0 - initial release
// ============================================================================
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              thread_count,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES*8-1:0]  core_block_id,
    output logic [NUM_CORES*TW-1:0] core_thread_count,
    output logic                    done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int                   c_LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam logic [15:0]          c_TPB_W    = 16'(THREADS_PER_BLOCK);
    localparam logic [TW-1:0]        c_TPB_TW   = TW'(THREADS_PER_BLOCK);
    localparam logic [8:0]           c_ROUND    = 9'(THREADS_PER_BLOCK - 1);
    localparam logic [NUM_CORES-1:0] c_ONE      = NUM_CORES'(1);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic [7:0]              r_count;
    logic [7:0]              r_total;
    logic [7:0]              r_disp;
    logic [7:0]              r_bdone;
    logic [NUM_CORES-1:0]    r_core_start;
    logic [NUM_CORES-1:0]    r_core_reset;
    logic [NUM_CORES*8-1:0]  r_block_id;
    logic [NUM_CORES*TW-1:0] r_tcnt;
    logic                    r_done;

    logic                    w_launch;
    logic                    w_run;
    logic [7:0]              w_total;
    logic [NUM_CORES-1:0]    w_eligible;
    logic [NUM_CORES-1:0]    w_grant;
    logic [NUM_CORES-1:0]    w_counted;
    logic [7:0]              w_popcnt;
    logic [15:0]             w_rem;
    logic [TW-1:0]           w_blk_cnt;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RUN;
            c_RUN:   if (r_bdone == r_total) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_DONE;
            default: w_next_state = c_IDLE;
        endcase
    end

    assign w_launch = (r_state == c_IDLE) && start;
    assign w_run    = (r_state == c_RUN);

    // Ceiling division done in 9 bits so thread_count near 255 cannot wrap
    // before the shift; the result always fits back into 8 bits.
    assign w_total = 8'(({1'b0, thread_count} + c_ROUND) >> c_LOG2_TPB);

    // Idle cores compete only while undispatched blocks remain; the
    // two's-complement trick isolates the lowest-index requester.
    assign w_eligible = (w_run && (r_disp < r_total)) ? r_core_reset : '0;
    assign w_grant    = w_eligible & (~w_eligible + c_ONE);

    // Completion pulses from cores that do not own a block are ignored.
    assign w_counted = w_run ? (core_done & r_core_start) : '0;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_popcnt = w_popcnt + 8'(w_counted[i]);
        end
    end

    // Threads left for the block about to be dispatched; always nonzero
    // whenever a grant is possible, so only the upper clamp is needed.
    assign w_rem     = {8'b0, r_count} - ({8'b0, r_disp} << c_LOG2_TPB);
    assign w_blk_cnt = (w_rem >= c_TPB_W) ? c_TPB_TW : w_rem[TW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_count      <= '0;
            r_total      <= '0;
            r_disp       <= '0;
            r_bdone      <= '0;
            r_core_start <= '0;
            r_core_reset <= '1;
            r_block_id   <= '0;
            r_tcnt       <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == c_DONE);

            if (w_launch) begin
                r_count <= thread_count;
                r_total <= w_total;
                r_disp  <= '0;
                r_bdone <= '0;
            end

            if (w_run) begin
                r_bdone <= r_bdone + w_popcnt;
                if (|w_grant) begin
                    r_disp <= r_disp + 8'd1;
                end
                // A granted core is idle, so it can never also be counted
                // complete in the same cycle.
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (w_counted[i]) begin
                        r_core_start[i] <= 1'b0;
                        r_core_reset[i] <= 1'b1;
                    end
                    if (w_grant[i]) begin
                        r_core_start[i]       <= 1'b1;
                        r_core_reset[i]       <= 1'b0;
                        r_block_id[i*8 +: 8]  <= r_disp;
                        r_tcnt[i*TW +: TW]    <= w_blk_cnt;
                    end
                end
            end
        end
    end

    assign core_start        = r_core_start;
    assign core_reset        = r_core_reset;
    assign core_block_id     = r_block_id;
    assign core_thread_count = r_tcnt;
    assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_block_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_dispatcher
// Purpose  : Self-checking bench for block_dispatcher (2 cores, 4 threads per
//            block): directed vector table, hand-written multi-cycle
//            sequences, then random stimulus against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      thread_count;
    logic [NC-1:0]   core_done;
    logic [NC-1:0]   core_start;
    logic [NC-1:0]   core_reset;
    logic [NC*8-1:0] core_block_id;
    logic [NC*TW-1:0] core_thread_count;
    logic            done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    block_dispatcher #(
        .NUM_CORES         (NC),
        .THREADS_PER_BLOCK (TPB),
        .TW                (TW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done)
    );

    typedef struct {
        bit         rn;
        bit         st;
        logic [7:0] tc;
        logic [1:0] cd;
        logic [1:0] es;
        logic [1:0] er;
        logic [15:0] eid;
        logic [5:0] ec;
        bit         ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rn, input bit st, input logic [7:0] tc, input logic [1:0] cd,
                       input logic [1:0] es, input logic [1:0] er, input logic [15:0] eid,
                       input logic [5:0] ec, input bit ed);
        vec_t v;
        v.rn = rn; v.st = st; v.tc = tc; v.cd = cd;
        v.es = es; v.er = er; v.eid = eid; v.ec = ec; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic apply(input bit rn, input bit st, input logic [7:0] tc, input logic [1:0] cd);
        reset        = rn;
        start        = st;
        thread_count = tc;
        core_done    = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] es, input logic [1:0] er,
                         input logic [15:0] eid, input logic [5:0] ec, input logic ed);
        total++;
        if (core_start !== es || core_reset !== er || core_block_id !== eid ||
            core_thread_count !== ec || done !== ed) begin
            bad++;
            $display("FAIL %s: got start=%b reset=%b id=%h cnt=%h done=%b, want start=%b reset=%b id=%h cnt=%h done=%b",
                     name, core_start, core_reset, core_block_id, core_thread_count, done,
                     es, er, eid, ec, ed);
        end
    endtask

    // ---------------- reference model ----------------
    int m_phase;          // 0 idle, 1 running, 2 finished
    int m_cnt, m_total, m_disp, m_ndone;
    bit m_busy [NC];
    int m_id   [NC];
    int m_tcnt [NC];
    bit m_done;

    task automatic model_step(input bit rn, input bit st, input int tc, input logic [1:0] cd);
        bit old_busy [NC];
        bit given;
        bit finished;
        if (!rn) begin
            m_phase = 0; m_cnt = 0; m_total = 0; m_disp = 0; m_ndone = 0; m_done = 0;
            for (int i = 0; i < NC; i++) begin
                m_busy[i] = 0; m_id[i] = 0; m_tcnt[i] = 0;
            end
        end else if (m_phase == 0) begin
            if (st) begin
                m_phase = 1; m_cnt = tc; m_total = (tc + TPB - 1) / TPB;
                m_disp = 0; m_ndone = 0;
            end
        end else if (m_phase == 1) begin
            finished = (m_ndone == m_total);
            for (int i = 0; i < NC; i++) old_busy[i] = m_busy[i];
            for (int i = 0; i < NC; i++) begin
                if (old_busy[i] && cd[i]) begin
                    m_busy[i] = 0;
                    m_ndone++;
                end
            end
            given = 0;
            for (int i = 0; i < NC; i++) begin
                if (!given && !old_busy[i] && m_disp < m_total) begin
                    given = 1;
                    m_busy[i] = 1;
                    m_id[i]   = m_disp;
                    m_tcnt[i] = (m_cnt - TPB * m_disp > TPB) ? TPB : m_cnt - TPB * m_disp;
                    m_disp++;
                end
            end
            if (finished) begin
                m_phase = 2;
                m_done  = 1;
            end
        end
    endtask

    task automatic check_model(input string name);
        logic [1:0]  es;
        logic [15:0] eid;
        logic [5:0]  ec;
        for (int i = 0; i < NC; i++) begin
            es[i]          = m_busy[i];
            eid[i*8 +: 8]  = 8'(m_id[i]);
            ec[i*TW +: TW] = TW'(m_tcnt[i]);
        end
        check(name, es, ~es, eid, ec, m_done);
    endtask

    initial begin
        apply(0, 0, 8'h00, 2'b00);

        // reset values (3 cycles)
        for (int k = 0; k < 3; k++) add(0,0,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,0);
        // exact fit, 8 threads
        add(1,1,8'h08,2'b00, 2'b00,2'b11,16'h0000,6'h00,0);
        add(1,0,8'h08,2'b00, 2'b01,2'b10,16'h0000,6'h04,0);
        add(1,0,8'h08,2'b00, 2'b11,2'b00,16'h0100,6'h24,0);
        add(1,0,8'h08,2'b11, 2'b00,2'b11,16'h0100,6'h24,0);
        add(1,0,8'h08,2'b00, 2'b00,2'b11,16'h0100,6'h24,1);
        add(0,0,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,0);
        // remainder, 10 threads; thread_count changed after launch
        add(1,1,8'h0A,2'b00, 2'b00,2'b11,16'h0000,6'h00,0);
        add(1,0,8'hFF,2'b00, 2'b01,2'b10,16'h0000,6'h04,0);
        add(1,0,8'hFF,2'b00, 2'b11,2'b00,16'h0100,6'h24,0);
        add(1,0,8'hFF,2'b10, 2'b01,2'b10,16'h0100,6'h24,0);
        add(1,0,8'hFF,2'b00, 2'b11,2'b00,16'h0200,6'h14,0);
        add(1,0,8'hFF,2'b01, 2'b10,2'b01,16'h0200,6'h14,0);
        add(1,0,8'hFF,2'b10, 2'b00,2'b11,16'h0200,6'h14,0);
        add(1,0,8'hFF,2'b00, 2'b00,2'b11,16'h0200,6'h14,1);
        add(0,0,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,0);
        // zero threads (spurious done at launch), start ignored afterwards
        add(1,1,8'h00,2'b11, 2'b00,2'b11,16'h0000,6'h00,0);
        add(1,0,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,1);
        add(1,1,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,1);
        add(1,0,8'h00,2'b00, 2'b00,2'b11,16'h0000,6'h00,1);

        foreach (vecs[k]) begin
            apply(vecs[k].rn, vecs[k].st, vecs[k].tc, vecs[k].cd);
            tick();
            check($sformatf("vec%0d", k), vecs[k].es, vecs[k].er, vecs[k].eid, vecs[k].ec, vecs[k].ed);
        end

        // simultaneous completion, 16 threads
        apply(0,0,8'h00,2'b00); tick(); check("sim_rst",  2'b00,2'b11,16'h0000,6'h00,0);
        apply(1,1,8'h10,2'b00); tick(); check("sim_go",   2'b00,2'b11,16'h0000,6'h00,0);
        apply(1,0,8'h10,2'b00); tick(); check("sim_b0",   2'b01,2'b10,16'h0000,6'h04,0);
        tick();                         check("sim_b1",   2'b11,2'b00,16'h0100,6'h24,0);
        apply(1,0,8'h10,2'b11); tick(); check("sim_rel",  2'b00,2'b11,16'h0100,6'h24,0);
        apply(1,0,8'h10,2'b00); tick(); check("sim_b2",   2'b01,2'b10,16'h0102,6'h24,0);
        tick();                         check("sim_b3",   2'b11,2'b00,16'h0302,6'h24,0);
        apply(1,0,8'h10,2'b11); tick(); check("sim_rel2", 2'b00,2'b11,16'h0302,6'h24,0);
        apply(1,0,8'h10,2'b00); tick(); check("sim_done", 2'b00,2'b11,16'h0302,6'h24,1);

        // abort mid-run, relaunch, spurious start and done
        apply(0,0,8'h00,2'b00); tick();
        apply(1,1,8'h10,2'b00); tick();
        apply(1,0,8'h10,2'b00); tick(); check("ab_b0",    2'b01,2'b10,16'h0000,6'h04,0);
        apply(0,0,8'h10,2'b00); tick(); check("ab_rst",   2'b00,2'b11,16'h0000,6'h00,0);
        apply(1,1,8'h08,2'b00); tick(); check("ab_go",    2'b00,2'b11,16'h0000,6'h00,0);
        apply(1,0,8'h08,2'b10); tick(); check("ab_b0b",   2'b01,2'b10,16'h0000,6'h04,0);
        apply(1,1,8'h08,2'b10); tick(); check("ab_b1",    2'b11,2'b00,16'h0100,6'h24,0);
        apply(1,0,8'h08,2'b01); tick(); check("ab_rel0",  2'b10,2'b01,16'h0100,6'h24,0);
        apply(1,0,8'h08,2'b00); tick(); check("ab_hold",  2'b10,2'b01,16'h0100,6'h24,0);
        apply(1,0,8'h08,2'b10); tick(); check("ab_rel1",  2'b00,2'b11,16'h0100,6'h24,0);
        apply(1,0,8'h08,2'b00); tick(); check("ab_done",  2'b00,2'b11,16'h0100,6'h24,1);

        // random stimulus against the reference model
        for (int k = 0; k < 1500; k++) begin
            bit         rn;
            bit         st;
            logic [7:0] tc;
            logic [1:0] cd;
            if (k == 0)
                rn = 0;
            else if (m_phase == 2)
                rn = ($urandom_range(0, 4) != 0);
            else
                rn = ($urandom_range(0, 199) != 0);
            st = ($urandom_range(0, 3) == 0);
            tc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            cd = 2'($urandom_range(0, 3));
            apply(rn, st, tc, cd);
            model_step(rn, st, int'(tc), cd);
            tick();
            check_model($sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
